// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: key synchronizers/debouncers and start/stop/lap/clear FSM.
// Optional LONG_PRESS_CLR_EN: holding lap/reset for LONG_PRESS_MS forces a clear to IDLE.

// Single-key synchronizer + debouncer with a registered one-cycle press pulse.
module stopwatch_debounce #(
  parameter int unsigned DB_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      level        <= 1'b1;
      level_last_q <= 1'b1;
      press        <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      // Count consecutive cycles the synchronized level disagrees; the compare
      // against CNT_LAST also keeps the counter from ever running past it.
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q >= CNT_LAST) begin
        level <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      level_last_q <= level;
      press        <= level_last_q & ~level;
    end
  end

endmodule

module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       key_ss_n,
  input  logic       key_lr_n,
  output logic       run,
  output logic       clr,
  output logic       freeze,
  output logic [1:0] state
);

  localparam int unsigned DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LP_CYC = CLK_HZ / 1000 * LONG_PRESS_MS;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10,
    S_LAP  = 2'b11
  } state_t;

  state_t state_q;
  logic   ss_level;
  logic   ss_press;
  logic   lr_level;
  logic   lr_press;
  logic   lp_evt;

  stopwatch_debounce #(.DB_CYC(DB_CYC)) u_db_ss (
    .clk   (clk_50m),
    .rst   (rst),
    .key_n (key_ss_n),
    .level (ss_level),
    .press (ss_press)
  );

  stopwatch_debounce #(.DB_CYC(DB_CYC)) u_db_lr (
    .clk   (clk_50m),
    .rst   (rst),
    .key_n (key_lr_n),
    .level (lr_level),
    .press (lr_press)
  );

`ifdef LONG_PRESS_CLR_EN
  localparam int unsigned LW = $clog2(LP_CYC) + 1;
  localparam logic [LW-1:0] LP_LAST = LW'(LP_CYC - 1);
  localparam logic [LW-1:0] LP_MAX  = LW'(LP_CYC);

  logic [LW-1:0] lp_cnt_q;
  logic          unused_level;

  assign unused_level = ss_level;

  // Hold-time counter; parks at LP_MAX so the event fires once per hold.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      lp_cnt_q <= '0;
      lp_evt   <= 1'b0;
    end else begin
      if (lr_level) begin
        lp_cnt_q <= '0;
      end else if (lp_cnt_q < LP_MAX) begin
        lp_cnt_q <= lp_cnt_q + LW'(1);
      end
      lp_evt <= ~lr_level && (lp_cnt_q == LP_LAST);
    end
  end
`else
  logic unused_level;

  assign unused_level = ^{ss_level, lr_level};
  assign lp_evt       = 1'b0;
`endif

  // Control FSM; run/freeze are re-decoded alongside every state change and
  // clr is refused if it was already high, so it can never stretch.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= S_IDLE;
      run     <= 1'b0;
      freeze  <= 1'b0;
      clr     <= 1'b0;
    end else begin
      clr <= 1'b0;
      if (lp_evt) begin
        state_q <= S_IDLE;
        run     <= 1'b0;
        freeze  <= 1'b0;
        clr     <= ~clr;
      end else if (ss_press) begin
        case (state_q)
          S_RUN, S_LAP: begin
            state_q <= S_STOP;
            run     <= 1'b0;
            freeze  <= 1'b0;
          end
          default: begin
            state_q <= S_RUN;
            run     <= 1'b1;
            freeze  <= 1'b0;
          end
        endcase
      end else if (lr_press) begin
        case (state_q)
          S_IDLE: begin
            clr <= ~clr;
          end
          S_RUN: begin
            state_q <= S_LAP;
            run     <= 1'b1;
            freeze  <= 1'b1;
          end
          S_LAP: begin
            state_q <= S_RUN;
            run     <= 1'b1;
            freeze  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            run     <= 1'b0;
            freeze  <= 1'b0;
            clr     <= ~clr;
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized + directed bench for stopwatch_ctrl against an edge-indexed behavioural model.
// Compile with +define+LONG_PRESS_CLR_EN to cover the long-press clear.
module tb_stopwatch_ctrl;

  localparam int DB   = 3;
  localparam int LP   = 10;
  localparam int MAXE = 8192;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic       key_ss_n;
  logic       key_lr_n;
  logic       run;
  logic       clr;
  logic       freeze;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int clr_cnt  = 0;
  bit clr_prev = 1'b0;

  // Per-edge history: value after edge i.
  bit m_rst [MAXE];
  bit raw_ss[MAXE];
  bit raw_lr[MAXE];
  bit syn_ss[MAXE];
  bit syn_lr[MAXE];
  bit db_ss [MAXE];
  bit db_lr [MAXE];
  bit pr_ss [MAXE];
  bit pr_lr [MAXE];
  bit lp_ev [MAXE];
  bit clr_m [MAXE];
  int st_m  [MAXE];

  // Transition tables indexed by state code IDLE=0 RUN=1 STOP=2 LAP=3.
  int ss_next[4] = '{1, 2, 1, 2};
  int lr_next[4] = '{0, 3, 0, 1};
  bit lr_clr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int exp_seq[5] = '{1, 3, 1, 2, 0};

  stopwatch_ctrl #(
    .CLK_HZ        (1000),
    .DEBOUNCE_MS   (3),
    .LONG_PRESS_MS (10)
  ) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .key_ss_n (key_ss_n),
    .key_lr_n (key_lr_n),
    .run      (run),
    .clr      (clr),
    .freeze   (freeze),
    .state    (state)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  function automatic bit syn_at(input bit lr, input int i);
    return lr ? syn_lr[i] : syn_ss[i];
  endfunction

  function automatic bit db_at(input bit lr, input int i);
    return lr ? db_lr[i] : db_ss[i];
  endfunction

  // Debounced level flips once the last DB synchronized samples all disagree with it.
  function automatic bit new_level(input bit lr, input int e);
    bit prev = db_at(lr, e - 1);
    if (e < DB) return prev;
    for (int i = e - DB; i < e; i++)
      if (syn_at(lr, i) == prev) return prev;
    return ~prev;
  endfunction

  function automatic bit fell(input bit lr, input int e);
    return (e >= 2) && db_at(lr, e - 2) && !db_at(lr, e - 1);
  endfunction

  function automatic bit long_hold(input int e);
    if (e < LP + 1) return 1'b0;
    if (!db_lr[e - LP - 1]) return 1'b0;
    for (int i = e - LP; i < e; i++)
      if (db_lr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit ss_n, input bit lr_n);
    int st;
    bit c;
    m_rst[n]  = r;
    raw_ss[n] = ss_n;
    raw_lr[n] = lr_n;
    if (r || n == 0 || m_rst[n-1]) begin
      syn_ss[n] = 1'b1;
      syn_lr[n] = 1'b1;
    end else begin
      syn_ss[n] = raw_ss[n-1];
      syn_lr[n] = raw_lr[n-1];
    end
    if (r || n == 0) begin
      db_ss[n] = 1'b1;
      db_lr[n] = 1'b1;
      pr_ss[n] = 1'b0;
      pr_lr[n] = 1'b0;
      lp_ev[n] = 1'b0;
      st_m[n]  = 0;
      clr_m[n] = 1'b0;
    end else begin
      db_ss[n] = new_level(1'b0, n);
      db_lr[n] = new_level(1'b1, n);
      pr_ss[n] = fell(1'b0, n);
      pr_lr[n] = fell(1'b1, n);
`ifdef LONG_PRESS_CLR_EN
      lp_ev[n] = long_hold(n);
`else
      lp_ev[n] = 1'b0;
`endif
      st = st_m[n-1];
      c  = 1'b0;
      if (lp_ev[n-1]) begin
        st = 0;
        c  = 1'b1;
      end else if (pr_ss[n-1]) begin
        st = ss_next[st];
      end else if (pr_lr[n-1]) begin
        c  = lr_clr[st];
        st = lr_next[st];
      end
      st_m[n]  = st;
      clr_m[n] = c && !clr_m[n-1];
    end
  endtask

  task automatic tick(input bit r, input bit ss_n, input bit lr_n);
    int st;
    rst      = r;
    key_ss_n = ss_n;
    key_lr_n = lr_n;
    @(posedge clk_50m);
    if (n >= MAXE) begin
      $display("FAIL edge_budget edge=%0d got=%0d expected<%0d", n, n, MAXE);
      $fatal(1, "edge budget exceeded");
    end
    model_edge(r, ss_n, lr_n);
    #1;
    st = st_m[n];
    check("state",  int'(state),  st);
    check("run",    int'(run),    int'(st == 1 || st == 3));
    check("freeze", int'(freeze), int'(st == 3));
    check("clr",    int'(clr),    int'(clr_m[n]));
    check("clr_single", int'(clr && clr_prev), 0);
    clr_prev = clr;
    if (clr) clr_cnt++;
    n++;
  endtask

  task automatic hold(input bit ss_n, input bit lr_n, input int cyc);
    for (int i = 0; i < cyc; i++) tick(1'b0, ss_n, lr_n);
  endtask

  initial begin
    // Reset values
    tick(1'b1, 1'b1, 1'b1);
    check("rst_state",  int'(state),  0);
    check("rst_run",    int'(run),    0);
    check("rst_freeze", int'(freeze), 0);
    check("rst_clr",    int'(clr),    0);

    // Start/stop held from the first post-reset edge: RUN exactly 6 edges later
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (i == 5) check("ss_latency_early", int'(state), 0);
    end
    check("ss_latency_state", int'(state), 1);
    check("ss_latency_run",   int'(run),   1);
    hold(1'b1, 1'b1, 10);

    // Bounces shorter than the debounce window never register
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 1'b1, 2);
      hold(1'b1, 1'b1, 2);
    end
    hold(1'b1, 1'b1, 6);
    check("bounce_state", int'(state), 0);
    check("bounce_run",   int'(run),   0);

    // ss, lr, lr, ss, lr walk through RUN, LAP, RUN, STOP, IDLE
    tick(1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 5; j++) begin
      clr_cnt = 0;
      if (j == 0 || j == 3) hold(1'b0, 1'b1, 8);
      else                  hold(1'b1, 1'b0, 8);
      hold(1'b1, 1'b1, 8);
      check("seq_state",  int'(state),  exp_seq[j]);
      check("seq_freeze", int'(freeze), int'(exp_seq[j] == 3));
      check("seq_clr_pulses", clr_cnt, int'(j == 4));
    end

    // Simultaneous presses from IDLE: start/stop wins, no clear
    tick(1'b1, 1'b1, 1'b1);
    clr_cnt = 0;
    hold(1'b0, 1'b0, 8);
    hold(1'b1, 1'b1, 8);
    check("simul_state", int'(state), 1);
    check("simul_clr",   clr_cnt,     0);

    // Long hold of lap/reset while running
    clr_cnt = 0;
    hold(1'b1, 1'b0, 20);
`ifdef LONG_PRESS_CLR_EN
    check("long_state", int'(state), 0);
    check("long_clr",   clr_cnt,     1);
`else
    check("long_state", int'(state), 3);
    check("long_clr",   clr_cnt,     0);
`endif
    hold(1'b1, 1'b1, 8);
`ifdef LONG_PRESS_CLR_EN
    check("long_release_clr", clr_cnt, 1);
`else
    check("long_release_clr", clr_cnt, 0);
`endif

    // Reset while in LAP
    tick(1'b1, 1'b1, 1'b1);
    hold(1'b0, 1'b1, 8);
    hold(1'b1, 1'b1, 8);
    hold(1'b1, 1'b0, 8);
    hold(1'b1, 1'b1, 8);
    check("lap_state",  int'(state),  3);
    check("lap_freeze", int'(freeze), 1);
    tick(1'b1, 1'b1, 1'b1);
    check("lap_rst_state",  int'(state),  0);
    check("lap_rst_run",    int'(run),    0);
    check("lap_rst_freeze", int'(freeze), 0);
    check("lap_rst_clr",    int'(clr),    0);

    // Random key activity with bounces, overlaps and occasional resets
    for (int s = 0; s < 300; s++) begin
      bit ss_n;
      bit lr_n;
      int len;
      ss_n = 1'($urandom_range(0, 1));
      lr_n = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 14);
      if ($urandom_range(0, 59) == 0) tick(1'b1, ss_n, lr_n);
      else                            hold(ss_n, lr_n, len);
    end
    hold(1'b1, 1'b1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control front-end for the six-digit stopwatch counter chain. Debounces the two board push-buttons and runs the start/stop/lap/clear state machine. Drives the chain's count enable, a one-cycle clear and a display-freeze (lap hold) strobe. Sits between the raw key pins and the 100 Hz divider/counter cascade, replacing direct key wiring.

## Interface
- CLK_HZ, 50_000_000: clock frequency in Hz.
- DEBOUNCE_MS, 20: required stable time of a key level; DB_CYC = CLK_HZ/1000*DEBOUNCE_MS cycles.
- LONG_PRESS_MS, 1000: lap/reset hold time for forced clear; LP_CYC = CLK_HZ/1000*LONG_PRESS_MS cycles.

- clk_50m  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_ss_n  in  1  start/stop key, active-low, asynchronous.
- key_lr_n  in  1  lap/reset key, active-low, asynchronous.
- run  out  1  count enable to counter chain (1 = counting).
- clr  out  1  one-cycle synchronous clear of all counters.
- freeze  out  1  1 = display latches hold last value.
- state  out  2  FSM state: IDLE=00, RUN=01, STOP=10, LAP=11.

## Operation
- Each key: 2-FF synchronizer (reset value 1), then debouncer. Counter runs while the synchronized level differs from the debounced level, and clears to 0 when they match. When it reaches DB_CYC-1 with levels still differing, the debounced level takes the new value.
- Press event: one-cycle pulse on a debounced 1->0 transition. Release generates no event.
- FSM transitions on press events:
  - IDLE: ss -> RUN. lr -> stay IDLE, assert clr.
  - RUN: ss -> STOP. lr -> LAP.
  - LAP: lr -> RUN. ss -> STOP.
  - STOP: ss -> RUN. lr -> IDLE, assert clr.
- Outputs, registered and decoded from the state:
  - run = 1 in RUN and LAP.
  - freeze = 1 in LAP only.
  - clr = 1 only in the cycle after a clearing transition.
- Simultaneous ss and lr events in one cycle: ss is processed and lr is discarded.
- Event during the clr cycle: processed normally from the new state.
- Debounce counters are $clog2(DB_CYC)+1 bits; long-press counter is $clog2(LP_CYC)+1 bits. Counters saturate and never wrap.

## Timing
- Reset values: state=IDLE, run=0, freeze=0, clr=0, synchronizers=1, debounced levels=1 (released), all counters 0.
- A key low that is first sampled at edge k produces the press event at edge k+DB_CYC+2. FSM and outputs update at edge k+DB_CYC+3.
- Any bounce shorter than DB_CYC cycles resets the counter and produces no event.
- Reset asserted mid-operation (including mid-debounce or during clr): all outputs return to reset values on the next edge. A key held through reset release is seen as a fresh press after full debounce.
- clr is never asserted for more than one consecutive cycle.

## Configuration
- LONG_PRESS_CLR_EN defined:
  - A counter runs while the debounced lr level is 0.
  - At LP_CYC it fires a long-press event once per hold; it rearms after release.
  - The event forces IDLE from any state and asserts clr for one cycle, overriding any ss event in the same cycle.
  - The earlier short-press lr action still takes effect at press time.
- LONG_PRESS_CLR_EN undefined: no long-press counter is built; only short-press behaviour applies.

## Test plan
All scenarios use CLK_HZ=1000, DEBOUNCE_MS=3 (DB_CYC=3), LONG_PRESS_MS=10 (LP_CYC=10).
- Reset, then ss held low from edge 0 -> state=01, run=1 at edge 6; freeze=0, clr=0 throughout.
- ss low for 2 cycles then high, repeated 5 times -> no event; state stays 00 and run=0.
- Sequence ss, lr, lr, ss, lr, each held 8 cycles with 8-cycle gaps -> states 01,11,01,10,00. freeze=1 only in 11. clr single-cycle pulse on entry to 00.
- ss and lr fall in the same cycle from IDLE -> state=01, clr stays 0, lr event ignored.
- With LONG_PRESS_CLR_EN, in RUN hold lr 20 cycles -> LAP at DB_CYC+3, then IDLE with one clr pulse when the hold reaches LP_CYC. No second clr until release and re-press. Without the macro -> stays LAP.
- rst=1 for one cycle while in LAP -> next edge state=00, run=0, freeze=0, clr=0.
